// File: rtl/dma_regs_mc.sv
// rtl/dma_regs_mc.sv - multi-channel DMA descriptor registers with round-robin issue to one DMA engine
module dma_regs_mc #(
  parameter int NUM_CH     = 4,
  parameter int ADDR_ALIGN = 7,
  parameter int CH_W       = 2
) (
  input  logic                  ACLK,
  input  logic                  rst,
  input  logic [31:0]           bram_waddr,
  input  logic [31:0]           bram_wdata,
  input  logic [3:0]            bram_wstb,
  input  logic                  bram_wen,
  input  logic [31:0]           bram_raddr,
  input  logic                  bram_ren,
  input  logic                  bram_regen,
  output logic [31:0]           bram_rdata,
  output logic [31-ADDR_ALIGN:0] dma_addr,
  output logic [31:0]           dma_lba,
  output logic [31:0]           dma_cnt,
  output logic                  dma_type,
  output logic [CH_W-1:0]       dma_ch,
  output logic                  dma_start,
  input  logic                  dma_ready,
  input  logic                  dma_done,
  output logic                  irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_ACT  = 2'd2,
    ST_DONE = 2'd3
  } ch_state_t;

  localparam logic [31:0] UNMAPPED = 32'hd34db33f;

  logic [31:0]       r_addr [NUM_CH];
  logic [31:0]       r_lba  [NUM_CH];
  logic [31:0]       r_cnt  [NUM_CH];
  logic [31:0]       r_last [NUM_CH];
  logic [NUM_CH-1:0] r_type;
  logic [NUM_CH-1:0] r_ovr;
  logic [NUM_CH-1:0] r_irq_stat;
  logic [31:0]       r_irq_mask;
  ch_state_t         r_state [NUM_CH];

  ch_state_t         w_state_nxt [NUM_CH];
  logic [NUM_CH-1:0] w_ovr_nxt;
  logic [NUM_CH-1:0] w_done;
  logic [NUM_CH-1:0] w_sel;
  logic [NUM_CH-1:0] w_start;
  logic [NUM_CH-1:0] w_clr_ovr;
  logic [NUM_CH-1:0] w_lock;
  logic [NUM_CH-1:0] w_irq_clr;

  logic [7:0]        r_raddr;
  logic [31:0]       r_rdata;
  logic [31:0]       w_rdata;

  logic [CH_W-1:0]   r_rr_ptr;
  logic [CH_W-1:0]   r_dma_ch;
  logic              r_dma_start;
  logic [31-ADDR_ALIGN:0] r_dma_addr;
  logic [31:0]       r_dma_lba;
  logic [31:0]       r_dma_cnt;
  logic              r_dma_type;

  logic [7:0]        w_wa;
  logic              w_wmap;
  logic              w_rmap;
  logic              w_irq_stat_wr;
  logic              w_irq_mask_wr;
  logic              w_any_act;
  logic              w_pick_vld;
  logic              w_grant;
  logic              w_accept;
  int                w_pick_i;
  int                w_idx;
  logic              w_unused;

  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  stb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (stb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  assign w_wa          = bram_waddr[7:0];
  assign w_wmap        = ({1'b0, w_wa} < 9'(NUM_CH*8));
  assign w_rmap        = ({1'b0, r_raddr} < 9'(NUM_CH*8));
  assign w_irq_stat_wr = bram_wen && (w_wa == 8'hF8);
  assign w_irq_mask_wr = bram_wen && (w_wa == 8'hF9);
  assign w_accept      = r_dma_start && dma_ready;
  assign w_unused      = ^{bram_waddr[31:8], bram_raddr[31:8]};

  always_comb begin
    w_sel     = '0;
    w_start   = '0;
    w_clr_ovr = '0;
    w_lock    = '0;
    w_irq_clr = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_sel[c]     = bram_wen && w_wmap && (w_wa[6:3] == 4'(c));
      w_start[c]   = w_sel[c] && (w_wa[2:0] == 3'd4) && bram_wstb[0] && bram_wdata[0];
      w_clr_ovr[c] = w_sel[c] && (w_wa[2:0] == 3'd4) && bram_wstb[0] && bram_wdata[1];
      w_lock[c]    = (r_state[c] == ST_PEND) || (r_state[c] == ST_ACT);
      w_irq_clr[c] = w_irq_stat_wr && bram_wstb[c/8] && bram_wdata[c];
    end
  end

  // Per-channel next state; a start that finds the channel busy only flags overrun.
  always_comb begin
    w_ovr_nxt = r_ovr;
    w_done    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_state_nxt[c] = r_state[c];
      if (w_clr_ovr[c]) w_ovr_nxt[c] = 1'b0;
      case (r_state[c])
        ST_IDLE, ST_DONE: begin
          if (w_start[c]) w_state_nxt[c] = ST_PEND;
        end
        ST_PEND: begin
          if (w_start[c]) w_ovr_nxt[c] = 1'b1;
          if (w_accept && (r_dma_ch == CH_W'(c))) w_state_nxt[c] = ST_ACT;
        end
        ST_ACT: begin
          if (w_start[c]) w_ovr_nxt[c] = 1'b1;
          if (dma_done) begin
            w_state_nxt[c] = ST_DONE;
            w_done[c]      = 1'b1;
          end
        end
        default: w_state_nxt[c] = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_any_act  = 1'b0;
    w_pick_vld = 1'b0;
    w_pick_i   = 0;
    w_idx      = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (r_state[c] == ST_ACT) w_any_act = 1'b1;
    end
    for (int k = 1; k <= NUM_CH; k++) begin
      w_idx = (int'(r_rr_ptr) + k) % NUM_CH;
      if (!w_pick_vld && (r_state[w_idx] == ST_PEND)) begin
        w_pick_vld = 1'b1;
        w_pick_i   = w_idx;
      end
    end
  end

  assign w_grant = w_pick_vld && !w_any_act && !r_dma_start;

  always_comb begin
    w_rdata = UNMAPPED;
    if (r_raddr == 8'hF8) begin
      w_rdata = 32'(r_irq_stat);
    end else if (r_raddr == 8'hF9) begin
      w_rdata = r_irq_mask;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_rmap && (r_raddr[6:3] == 4'(c))) begin
        case (r_raddr[2:0])
          3'd0:    w_rdata = r_addr[c];
          3'd1:    w_rdata = r_lba[c];
          3'd2:    w_rdata = r_cnt[c];
          3'd3:    w_rdata = {31'b0, r_type[c]};
          3'd4:    w_rdata = {27'b0, r_ovr[c], 2'b0, r_state[c]};
          3'd5:    w_rdata = r_last[c];
          default: w_rdata = UNMAPPED;
        endcase
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_state[c] <= ST_IDLE;
        r_addr[c]  <= '0;
        r_lba[c]   <= '0;
        r_cnt[c]   <= '0;
        r_last[c]  <= '0;
      end
      r_type      <= '0;
      r_ovr       <= '0;
      r_irq_stat  <= '0;
      r_irq_mask  <= '0;
      r_raddr     <= '0;
      r_rdata     <= '0;
      r_rr_ptr    <= CH_W'(NUM_CH-1);
      r_dma_start <= 1'b0;
      r_dma_ch    <= '0;
      r_dma_addr  <= '0;
      r_dma_lba   <= '0;
      r_dma_cnt   <= '0;
      r_dma_type  <= 1'b0;
    end else begin
      r_ovr <= w_ovr_nxt;
      for (int c = 0; c < NUM_CH; c++) begin
        r_state[c] <= w_state_nxt[c];
        if (w_sel[c] && !w_lock[c]) begin
          case (w_wa[2:0])
            3'd0:    r_addr[c] <= f_merge(r_addr[c], bram_wdata, bram_wstb);
            3'd1:    r_lba[c]  <= f_merge(r_lba[c], bram_wdata, bram_wstb);
            3'd2:    r_cnt[c]  <= f_merge(r_cnt[c], bram_wdata, bram_wstb);
            3'd3:    if (bram_wstb[0]) r_type[c] <= bram_wdata[0];
            default: ;
          endcase
        end
        if (w_done[c]) r_last[c] <= r_addr[c];
      end
      // Completion set is applied after the W1C clear so it wins a same-cycle race.
      r_irq_stat <= (r_irq_stat & ~w_irq_clr) | w_done;
      if (w_irq_mask_wr) r_irq_mask <= f_merge(r_irq_mask, bram_wdata, bram_wstb);

      if (bram_ren) r_raddr <= bram_raddr[7:0];
      if (bram_regen) r_rdata <= w_rdata;

      if (w_grant) begin
        r_dma_start <= 1'b1;
        r_dma_ch    <= CH_W'(w_pick_i);
        r_dma_addr  <= r_addr[w_pick_i][31:ADDR_ALIGN];
        r_dma_lba   <= r_lba[w_pick_i];
        r_dma_cnt   <= r_cnt[w_pick_i];
        r_dma_type  <= r_type[w_pick_i];
      end else if (w_accept) begin
        r_dma_start <= 1'b0;
        r_rr_ptr    <= r_dma_ch;
      end
    end
  end

  assign bram_rdata = r_rdata;
  assign dma_addr   = r_dma_addr;
  assign dma_lba    = r_dma_lba;
  assign dma_cnt    = r_dma_cnt;
  assign dma_type   = r_dma_type;
  assign dma_ch     = r_dma_ch;
  assign dma_start  = r_dma_start;
  assign irq        = |(r_irq_stat & r_irq_mask[NUM_CH-1:0]);

endmodule

// File: doc/dma_regs_mc.md
Name: dma_regs_mc

Overview:
- Parametrised multi-channel successor to the single-channel DMA command register block.
- Holds NUM_CH independent DMA descriptors (memory address, LBA, sector count, type), written and read over the AXI buffer port.
- Round-robin arbitration issues pending descriptors to a single DMA engine through a start/ready handshake.
- Tracks per-channel state, latches completion, and raises a maskable interrupt. Sits between the MAXI buffer interface and the SATA DMA engine.

Parameters:
- NUM_CH, 4, number of descriptor channels, 1..16.
- ADDR_ALIGN, 7, dma_addr LSB; address bits [ADDR_ALIGN-1:0] are forced to 0 on output.
- CH_W, 2, width of dma_ch; must satisfy 2**CH_W >= NUM_CH, minimum 1.

Ports:
- ACLK  in  1  single clock for all logic.
- rst  in  1  reset; synchronous and active-high.
- bram_waddr  in  32  write word address; bits [7:0] decoded.
- bram_wdata  in  32  write data.
- bram_wstb  in  4  byte strobes.
- bram_wen  in  1  write enable.
- bram_raddr  in  32  read word address; bits [7:0] decoded.
- bram_ren  in  1  read address capture.
- bram_regen  in  1  read data register enable.
- bram_rdata  out  32  read data.
- dma_addr  out  32-ADDR_ALIGN  granted channel address [31:ADDR_ALIGN].
- dma_lba  out  32  granted channel LBA.
- dma_cnt  out  32  granted channel sector count.
- dma_type  out  1  granted channel direction, 1 = write.
- dma_ch  out  CH_W  granted channel index.
- dma_start  out  1  request to engine; held until accepted.
- dma_ready  in  1  engine accepts the request in any cycle where dma_start && dma_ready.
- dma_done  in  1  one-cycle pulse: active transfer finished.
- irq  out  1  |(irq_status & irq_mask).

Behaviour:
- Address map, word address a = bram_waddr[7:0] or captured read address:
  - a < NUM_CH*8 selects channel c = a[6:3] and register index a[2:0].
  - Index 0: ADDR (rw). 1: LBA (rw). 2: CNT (rw). 3: TYPE (rw, bit0 used, reads zero-extended).
  - Index 4: CTRL/STAT. Write: bit0 = start, bit1 = clear overrun. Read: {27'b0, overrun, 2'b0, state[1:0]}.
  - Index 5: LAST (ro), ADDR value of the last completed transfer.
  - 0xF8: IRQ_STAT, bit c per channel, write-1-to-clear.
  - 0xF9: IRQ_MASK (rw).
  - All other addresses: reads return 32'hd34db33f, writes are ignored.
- Writes are byte-merged: only bytes with their wstb bit set change. This replaces the predecessor's AND-masking.
- ADDR, LBA, CNT and TYPE writes are ignored while the channel is PENDING or ACTIVE (descriptor locked).
- Per-channel FSM, state codes: IDLE=0, PENDING=1, ACTIVE=2, DONE=3.
  - IDLE or DONE + start (bit0 written with wstb[0]=1) -> PENDING on the next cycle.
  - PENDING + start -> state unchanged; overrun sets sticky. Same for ACTIVE + start.
  - PENDING + granted + dma_ready -> ACTIVE.
  - ACTIVE + dma_done -> DONE. On the same edge: LAST <= ADDR and IRQ_STAT[c] <= 1.
- Arbiter:
  - When no channel is ACTIVE and no request is outstanding, pick the first PENDING channel at or after rr_ptr+1 mod NUM_CH.
  - Next cycle: dma_start=1, dma_ch=c, dma_addr/dma_lba/dma_cnt/dma_type driven from channel c; all held stable until accept.
  - On accept: dma_start <= 0, rr_ptr <= c.
  - At most one request outstanding or one channel ACTIVE at any time. A new grant is possible at the earliest the cycle after DONE.
- dma_done with no ACTIVE channel is ignored.
- Same-cycle IRQ_STAT W1C and done-set on the same bit: set wins.
- Start write to a DONE channel returns it to PENDING; its IRQ_STAT bit is not cleared.
- Read path:
  - bram_ren captures raddr[7:0].
  - bram_regen loads bram_rdata from the captured address on the next edge; otherwise bram_rdata holds.
  - Read latency is 1 cycle after regen.
- Reset: all registers 0, all channels IDLE, overrun 0, rr_ptr = NUM_CH-1 (so ch0 is first), dma_start=0, dma_ch=0, irq=0, bram_rdata=0.
- Reset mid-transfer: the outstanding request is dropped immediately; a later dma_done is ignored.

Test Plan:
- Write ADDR0=0x12345FFF with wstb=4'b0011, then wstb=4'b1100 with 0xAB000000 -> read ADDR0 returns 0xAB005FFF after 1-cycle regen latency; dma_addr low bits read 0 when granted.
- Program ch0 and ch2, start both in the same burst, dma_ready=1 -> ch0 granted first. dma_done -> ch0 DONE, LAST0=ADDR0, IRQ_STAT=0x1. Then ch2 granted.
- dma_ready held low for 5 cycles -> dma_start and all descriptor outputs stable for 5 cycles; CNT write to the pending channel is ignored; second start sets overrun (STAT=0x11).
- IRQ_MASK=0 -> irq=0 although IRQ_STAT=1. Set mask=1 -> irq=1. W1C on the same cycle as a new done of that channel -> bit stays 1.
- Four channels restarted continuously -> grant order 0,1,2,3,0; no channel starved.
- rst asserted while ch1 ACTIVE -> next cycle all STAT read 0, dma_start=0; a subsequent dma_done leaves IRQ_STAT=0. Unmapped read of 0x80 (NUM_CH=4) returns 0xd34db33f.
